// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Sequential signed radix-2 Booth multiplier. It performs one Booth iteration
// per clock and produces the full 2*WIDTH-bit {HI,LO} product for MUL. The
// start/busy/done handshake matches the restoring divider, so the control
// unit stalls on busy the same way for both.
//
// Ports
//   clk           system clock; every state update happens on the rising edge
//   reset         synchronous, active-high; clears all state
//   start         multiply request; sampled only in IDLE
//   multiplicand  signed operand M; latched when start is accepted
//   multiplier    signed operand Q; latched when start is accepted
//   result        signed product {HI,LO}; changes only on completion or reset
//   hi, lo        upper and lower halves of result
//   busy          high for the WIDTH cycles of the RUN phase
//   done          one-cycle pulse in the cycle after the completion edge
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for start; result holds the last product
//   S_RUN  | one Booth add/sub plus arithmetic shift per clock
//   S_DONE | result valid and done pulsed; start is ignored here

module booth_multiplier_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // The accumulator is one bit wider than the operands so that subtracting
   // M = -2^(WIDTH-1) cannot overflow.
   logic [WIDTH:0]   m_reg;
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_m1;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   a_sum;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH-1:0] q_shift;
   logic             last_iter;

   assign last_iter = (count == LAST);

   // Booth recoding of {Q[0],Q-1}, followed by an arithmetic right shift of
   // {A,Q,Q-1}.
   always_comb begin
      a_sum = a_reg;
      case ({q_reg[0], q_m1})
         2'b01:   a_sum = a_reg + m_reg;
         2'b10:   a_sum = a_reg - m_reg;
         default: a_sum = a_reg;
      endcase
      a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
      q_shift = {a_sum[0], q_reg[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_iter) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_reg  <= '0;
         a_reg  <= '0;
         q_reg  <= '0;
         q_m1   <= 1'b0;
         count  <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m_reg <= {multiplicand[WIDTH-1], multiplicand};
                  a_reg <= '0;
                  q_reg <= multiplier;
                  q_m1  <= 1'b0;
                  count <= '0;
               end
            end
            S_RUN: begin
               a_reg <= a_shift;
               q_reg <= q_shift;
               q_m1  <= q_reg[0];
               count <= count + CW'(1);
               if (last_iter) begin
                  result <= {a_shift[WIDTH-1:0], q_shift};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign hi = result[2*WIDTH-1:WIDTH];
   assign lo = result[WIDTH-1:0];

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [63:0] result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   booth_multiplier_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .result       (result),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input string tag, input logic [31:0] m, input logic [31:0] q);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
   endtask

   // Waits for done; lat is the number of edges after the accept edge.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_mul(input string tag, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp);
      int lat;
      start_op(tag, m, q);
      wait_done(lat);
      check({tag, "_latency"}, 64'(lat), 64'd32);
      check({tag, "_result"}, result, exp);
      check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
      check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
      tick();
      check({tag, "_done_pulse_ends"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      int accepts;
      int dones;
      int last_accept;
      int done_cnt;
      logic prev_busy;
      logic prev_done;
      logic [31:0] cur_m, cur_q, acc_m, acc_q;
      logic signed [63:0] sm, sq, prod;

      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      tick();
      tick();
      reset = 1'b0;
      check("reset_result", result, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);

      do_mul("small_pos", 32'd10, 32'd3, 64'h0000_0000_0000_001E);
      do_mul("mixed_neg", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
      do_mul("mixed_pos", 32'd30480, 32'd11, 64'h0000_0000_0005_1DB0);
      do_mul("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      do_mul("neg_one", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      do_mul("zero_m", 32'd0, 32'h7FFF_FFFF, 64'd0);
      do_mul("min_pos", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);

      // Hold and ignore: starts with 99x99 during RUN and DONE must not matter.
      do_mul("hold_base", 32'd10, 32'd3, 64'd30);
      start_op("hold_next", 32'd4, 32'd5);
      lat = 0;
      while (!done && lat < 40) begin
         multiplicand = 32'd99;
         multiplier   = 32'd99;
         start        = (lat % 3 == 0);
         tick();
         lat++;
         if (!done) check("hold_result_during_run", result, 64'd30);
      end
      check("hold_latency", 64'(lat), 64'd32);
      check("hold_result", result, 64'd20);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_done_start_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      check("hold_no_extra_op", 64'(busy), 64'd0);
      check("hold_result_kept", result, 64'd20);

      // Continuous start with operands changing every cycle.
      accepts     = 0;
      dones       = 0;
      last_accept = -1;
      prev_busy   = 1'b0;
      prev_done   = 1'b0;
      acc_m       = '0;
      acc_q       = '0;
      for (int cyc = 0; cyc < 110; cyc++) begin
         cur_m        = 32'(cyc * 7 - 50);
         cur_q        = 32'(1000 - cyc * 13);
         multiplicand = cur_m;
         multiplier   = cur_q;
         start        = 1'b1;
         tick();
         if (busy && !prev_busy) begin
            if (last_accept >= 0) check("hs_accept_spacing", 64'(cyc - last_accept), 64'd34);
            last_accept = cyc;
            acc_m       = cur_m;
            acc_q       = cur_q;
            accepts++;
         end
         if (done) begin
            sm   = {{32{acc_m[31]}}, acc_m};
            sq   = {{32{acc_q[31]}}, acc_q};
            prod = sm * sq;
            check("hs_result", result, prod);
            dones++;
         end
         if (prev_done) check("hs_done_single", 64'(done), 64'd0);
         prev_busy = busy;
         prev_done = done;
      end
      start = 1'b0;
      check("hs_accepts", 64'(accepts), 64'd4);
      check("hs_dones", 64'(dones), 64'd3);
      lat = 0;
      while (busy && lat < 40) begin
         tick();
         lat++;
      end
      tick();
      tick();

      // Reset in the middle of RUN.
      start_op("rst_mid", 32'd12, 32'd5);
      for (int i = 0; i < 9; i++) tick();
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_result", result, 64'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("rst_mid_no_done", 64'(done_cnt), 64'd0);
      check("rst_mid_result_hold", result, 64'd0);
      do_mul("rst_after", 32'd12, 32'd5, 64'd60);

      // Reset and start on the same edge: reset wins.
      multiplicand = 32'd7;
      multiplier   = 32'd7;
      start        = 1'b1;
      reset        = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check("rst_start_busy", 64'(busy), 64'd0);
      check("rst_start_result", result, 64'd0);
      tick();
      check("rst_start_still_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed no_finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
